// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - commit/CSR-side signal bundle for the trap sequencer
//
// Purpose: groups every trap_ctrl signal except clock and reset.
// Ports (slave = trap_ctrl view):
//   in : trint/swint/exint interrupt lines, mie, mstatus_mie, mtvec, mepc, mode,
//        commit_valid/commit_pc/commit_exc/commit_code/commit_mret
//   out: trap_valid/trap_is_int/trap_code/trap_pc/trap_mode, mret_valid,
//        redirect_valid/redirect_pc, flush, busy
interface trap_ctrl_if;
  logic        trint;
  logic        swint;
  logic        exint;
  logic [63:0] mie;
  logic        mstatus_mie;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic [1:0]  mode;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        commit_exc;
  logic [3:0]  commit_code;
  logic        commit_mret;
  logic        trap_valid;
  logic        trap_is_int;
  logic [3:0]  trap_code;
  logic [63:0] trap_pc;
  logic [1:0]  trap_mode;
  logic        mret_valid;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic        busy;

  modport slave (
    input  trint, swint, exint, mie, mstatus_mie, mtvec, mepc, mode,
    input  commit_valid, commit_pc, commit_exc, commit_code, commit_mret,
    output trap_valid, trap_is_int, trap_code, trap_pc, trap_mode,
    output mret_valid, redirect_valid, redirect_pc, flush, busy
  );

  modport master (
    output trint, swint, exint, mie, mstatus_mie, mtvec, mepc, mode,
    output commit_valid, commit_pc, commit_exc, commit_code, commit_mret,
    input  trap_valid, trap_is_int, trap_code, trap_pc, trap_mode,
    input  mret_valid, redirect_valid, redirect_pc, flush, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/interrupt sequencer
//
// Purpose: picks one event per committing instruction (interrupt > exception
// > mret), issues a registered trap-entry or mret command plus fetch redirect,
// then holds flush for FLUSH_CYCLES cycles.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset
//   bus   - trap_ctrl_if.slave (interrupt lines, CSR values, commit info in;
//           trap/mret command, redirect, flush, busy out)
module trap_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cause_q, cause_d;
  logic        trap_valid_q, trap_valid_d;
  logic        trap_is_int_q, trap_is_int_d;
  logic [3:0]  trap_code_q, trap_code_d;
  logic [63:0] trap_pc_q, trap_pc_d;
  logic [1:0]  trap_mode_q, trap_mode_d;
  logic        mret_valid_q, mret_valid_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;

  logic        ext_en, sw_en, tmr_en, int_pend;
  logic [3:0]  cause_now;
  logic        take_int;
  logic [3:0]  int_code;
  logic [3:0]  code_sel;
  logic        fire;
  logic [63:0] tvec_base;

  // Only the three enable bits of mie matter here.
  logic unused_mie;
  assign unused_mie = ^{bus.mie[63:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0]};

  assign ext_en    = bus.exint & bus.mie[11];
  assign sw_en     = bus.swint & bus.mie[3];
  assign tmr_en    = bus.trint & bus.mie[7];
  assign int_pend  = (ext_en | sw_en | tmr_en) & bus.mstatus_mie;
  assign cause_now = ext_en ? 4'd11 : (sw_en ? 4'd3 : 4'd7);
  assign tvec_base = {bus.mtvec[63:2], 2'b00};

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    cause_d          = cause_q;
    trap_valid_d     = 1'b0;
    mret_valid_d     = 1'b0;
    redirect_valid_d = 1'b0;
    trap_is_int_d    = trap_is_int_q;
    trap_code_d      = trap_code_q;
    trap_pc_d        = trap_pc_q;
    trap_mode_d      = trap_mode_q;
    redirect_pc_d    = redirect_pc_q;
    take_int         = 1'b0;
    int_code         = cause_q;
    code_sel         = bus.commit_code;
    fire             = 1'b0;

    case (state_q)
      IDLE: begin
        take_int = int_pend;
        int_code = cause_now;
        // Interrupt during a bubble: remember it until a commit slot appears.
        if (int_pend && !bus.commit_valid) begin
          state_d = ARMED;
          cause_d = cause_now;
        end
      end
      ARMED: begin
        // Latched cause survives the line dropping, but not a global disable.
        take_int = bus.mstatus_mie;
        int_code = cause_q;
        if (!bus.mstatus_mie && !bus.commit_valid) state_d = IDLE;
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != FLUSH && bus.commit_valid) begin
      if (take_int || bus.commit_exc) begin
        code_sel      = take_int ? int_code : bus.commit_code;
        trap_valid_d  = 1'b1;
        trap_is_int_d = take_int;
        trap_code_d   = code_sel;
        trap_pc_d     = bus.commit_pc;
        trap_mode_d   = bus.mode;
        // Vectored mode only offsets interrupts; exceptions use the base.
        if (take_int && bus.mtvec[1:0] == 2'b01)
          redirect_pc_d = tvec_base + {58'd0, code_sel, 2'b00};
        else
          redirect_pc_d = tvec_base;
        fire = 1'b1;
      end else if (bus.commit_mret) begin
        mret_valid_d  = 1'b1;
        redirect_pc_d = bus.mepc;
        fire          = 1'b1;
      end else begin
        state_d = IDLE;
      end
      if (fire) begin
        redirect_valid_d = 1'b1;
        state_d          = FLUSH;
        cnt_d            = 4'(FLUSH_CYCLES - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      cnt_q            <= 4'd0;
      cause_q          <= 4'd0;
      trap_valid_q     <= 1'b0;
      trap_is_int_q    <= 1'b0;
      trap_code_q      <= 4'd0;
      trap_pc_q        <= 64'd0;
      trap_mode_q      <= 2'd0;
      mret_valid_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 64'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      cause_q          <= cause_d;
      trap_valid_q     <= trap_valid_d;
      trap_is_int_q    <= trap_is_int_d;
      trap_code_q      <= trap_code_d;
      trap_pc_q        <= trap_pc_d;
      trap_mode_q      <= trap_mode_d;
      mret_valid_q     <= mret_valid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.trap_valid     = trap_valid_q;
  assign bus.trap_is_int    = trap_is_int_q;
  assign bus.trap_code      = trap_code_q;
  assign bus.trap_pc        = trap_pc_q;
  assign bus.trap_mode      = trap_mode_q;
  assign bus.mret_valid     = mret_valid_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  // FLUSH is entered exactly one cycle after the event and lasts FLUSH_CYCLES.
  assign bus.flush          = (state_q == FLUSH);
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed scoreboard bench for trap_ctrl
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic        is_mret;
    logic        is_int;
    logic [3:0]  code;
    logic [63:0] pc;
    logic [1:0]  mode;
    logic [63:0] rpc;
  } ev_t;

  ev_t sb[$];

  trap_ctrl_if bus();

  trap_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_commit();
    bus.commit_valid = 1'b0;
    bus.commit_exc   = 1'b0;
    bus.commit_mret  = 1'b0;
    bus.commit_code  = 4'd0;
    bus.commit_pc    = 64'd0;
  endtask

  task automatic commit(input logic [63:0] pc, input logic exc, input logic [3:0] code,
                        input logic mret, input logic [1:0] md);
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.commit_exc   = exc;
    bus.commit_code  = code;
    bus.commit_mret  = mret;
    bus.mode         = md;
  endtask

  task automatic push(input logic is_mret, input logic is_int, input logic [3:0] code,
                      input logic [63:0] pc, input logic [1:0] md, input logic [63:0] rpc);
    ev_t e;
    e.is_mret = is_mret;
    e.is_int  = is_int;
    e.code    = code;
    e.pc      = pc;
    e.mode    = md;
    e.rpc     = rpc;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a command pulse, then compare it with the oldest
  // scoreboard entry. The pulse is expected in the very first sampled cycle.
  task automatic check_event(input string tag);
    int   waited;
    logic seen;
    ev_t  e;
    waited = 0;
    seen   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.trap_valid || bus.mret_valid) begin
        seen = 1'b1;
        break;
      end
      step();
      waited++;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(waited), 64'd0);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_mret_valid"}, 64'(bus.mret_valid), 64'(e.is_mret));
      check({tag, "_trap_valid"}, 64'(bus.trap_valid), 64'(!e.is_mret));
      check({tag, "_redir_valid"}, 64'(bus.redirect_valid), 64'd1);
      check({tag, "_redir_pc"}, bus.redirect_pc, e.rpc);
      check({tag, "_flush"}, 64'(bus.flush), 64'd1);
      if (!e.is_mret) begin
        check({tag, "_is_int"}, 64'(bus.trap_is_int), 64'(e.is_int));
        check({tag, "_code"}, 64'(bus.trap_code), 64'(e.code));
        check({tag, "_pc"}, bus.trap_pc, e.pc);
        check({tag, "_mode"}, 64'(bus.trap_mode), 64'(e.mode));
      end
    end
  endtask

  initial begin
    bus.trint = 1'b0;
    bus.swint = 1'b0;
    bus.exint = 1'b0;
    bus.mie = 64'd0;
    bus.mstatus_mie = 1'b0;
    bus.mtvec = 64'd0;
    bus.mepc = 64'd0;
    bus.mode = 2'd0;
    clear_commit();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state held for 10 idle cycles.
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_bits", 64'({bus.trap_valid, bus.trap_is_int, bus.mret_valid,
                             bus.redirect_valid, bus.flush, bus.busy}), 64'd0);
      check("rst_pcs", bus.trap_pc | bus.redirect_pc, 64'd0);
      check("rst_code_mode", 64'({bus.trap_code, bus.trap_mode}), 64'd0);
    end

    // Exception, direct mtvec.
    bus.mtvec = 64'h8000_0100;
    commit(64'h8000_0040, 1'b1, 4'd2, 1'b0, 2'd3);
    push(1'b0, 1'b0, 4'd2, 64'h8000_0040, 2'd3, 64'h8000_0100);
    step();
    clear_commit();
    check_event("exc");
    step();
    check("exc_flush_n2", 64'(bus.flush), 64'd1);
    check("exc_pulse_drop", 64'({bus.trap_valid, bus.redirect_valid}), 64'd0);
    check("exc_pc_held", bus.trap_pc, 64'h8000_0040);
    step();
    check("exc_flush_n3", 64'({bus.flush, bus.busy}), 64'd0);

    // Timer interrupt arriving in a bubble, line drops before the commit.
    bus.mie = 64'h80;
    bus.mstatus_mie = 1'b1;
    bus.trint = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("armed_busy", 64'({bus.busy, bus.flush, bus.trap_valid}), 64'b100);
    end
    bus.trint = 1'b0;
    step();
    check("armed_held", 64'(bus.busy), 64'd1);
    commit(64'h1000, 1'b0, 4'd0, 1'b0, 2'd3);
    push(1'b0, 1'b1, 4'd7, 64'h1000, 2'd3, 64'h8000_0100);
    step();
    clear_commit();
    check_event("bubble_int");
    step();
    step();
    check("bubble_idle", 64'(bus.busy), 64'd0);

    // All three sources with a commit, vectored mtvec.
    bus.mie = 64'h888;
    bus.mtvec = 64'h2001;
    bus.trint = 1'b1;
    bus.swint = 1'b1;
    bus.exint = 1'b1;
    commit(64'h3000, 1'b0, 4'd0, 1'b0, 2'd0);
    push(1'b0, 1'b1, 4'd11, 64'h3000, 2'd0, 64'h202C);
    step();
    clear_commit();
    bus.trint = 1'b0;
    bus.swint = 1'b0;
    bus.exint = 1'b0;
    check_event("vec_all");
    step();
    step();

    // Interrupt beats exception and mret on the same instruction.
    bus.swint = 1'b1;
    commit(64'h4000, 1'b1, 4'd5, 1'b1, 2'd1);
    push(1'b0, 1'b1, 4'd3, 64'h4000, 2'd1, 64'h200C);
    step();
    clear_commit();
    bus.swint = 1'b0;
    check_event("prio");
    step();
    step();

    // mret, with an exception committing during the flush.
    bus.mepc = 64'h8000_0200;
    commit(64'h5000, 1'b0, 4'd0, 1'b1, 2'd0);
    push(1'b1, 1'b0, 4'd0, 64'h0, 2'd0, 64'h8000_0200);
    step();
    commit(64'h5004, 1'b1, 4'd2, 1'b0, 2'd0);
    check_event("mret");
    step();
    clear_commit();
    check("flush_commit_ignored", 64'({bus.trap_valid, bus.mret_valid, bus.flush}), 64'b001);
    check("mret_code_held", 64'(bus.trap_code), 64'd3);
    step();
    check("mret_done", 64'({bus.trap_valid, bus.flush, bus.busy}), 64'd0);

    // ARMED discarded when global enable drops.
    bus.mie = 64'h80;
    bus.trint = 1'b1;
    step();
    check("arm2_busy", 64'(bus.busy), 64'd1);
    bus.trint = 1'b0;
    bus.mstatus_mie = 1'b0;
    step();
    check("arm2_discard", 64'(bus.busy), 64'd0);
    bus.mstatus_mie = 1'b1;
    commit(64'h6000, 1'b0, 4'd0, 1'b0, 2'd0);
    step();
    clear_commit();
    check("arm2_no_trap", 64'({bus.trap_valid, bus.busy}), 64'd0);

    // Reset while flushing.
    commit(64'h7000, 1'b1, 4'd4, 1'b0, 2'd2);
    push(1'b0, 1'b0, 4'd4, 64'h7000, 2'd2, 64'h2000);
    step();
    clear_commit();
    check_event("pre_rst");
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_flush", 64'({bus.flush, bus.busy, bus.trap_valid, bus.redirect_valid}), 64'd0);
    check("rst_mid_pcs", bus.trap_pc | bus.redirect_pc, 64'd0);
    step();
    reset = 1'b1;
    step();
    check("post_rst", 64'({bus.flush, bus.busy}), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
